lc3b_btb: RTL and testbench
===========================

# lc3b_btb

Two-way set-associative branch target buffer, sitting directly downstream of `btb_load`. It consumes `load_btb` and the resolved branch PC and target from the update stage, and stores them. It also answers same-cycle target lookups for the fetch stage's PC. Replacement uses one LRU bit per set; a flush input invalidates all entries.

## Interface
- `SETS`, default 4, number of sets; power of two, at least 2. `IDX = log2(SETS)`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fetch_pc`  in  16  PC being fetched (lc3b_word), word aligned.
- `fetch_valid`  in  1  `fetch_pc` is a real fetch; gates LRU touch on hit.
- `btb_hit`  out  1  `fetch_pc` matches a valid entry.
- `btb_target`  out  16  stored target on hit; 16'h0000 on miss.
- `load_btb`  in  1  write request, driven from `btb_load`.
- `update_pc`  in  16  PC of the resolved branch.
- `update_target`  in  16  resolved branch target.
- `flush`  in  1  invalidate every entry.

## Operation
- Address split:
  - index = pc[IDX:1]; pc[0] is ignored.
  - tag = pc[15:IDX+1] (13 bits at SETS=4).
- State per set:
  - per way: valid bit, tag, 16-bit target;
  - one `lru` bit naming the way to evict next.
- Lookup (combinational):
  - compare `fetch_pc` tag against both ways of its set.
  - `btb_hit` = OR of (valid && tag match).
  - `btb_target` = target of the matching way, else 0.
  - Both ways matching is impossible by construction; if it occurs, way 0 wins.
- Lookup LRU touch: on hit with `fetch_valid`=1, set `lru` of that set to the other way at the next edge.
- Load with `load_btb`=1:
  - Update hit (a valid way already holds the `update_pc` tag): overwrite that way's target; no allocation.
  - Otherwise allocate. Victim is way 0 if invalid, else way 1 if invalid, else the way named by `lru`.
  - Victim gets valid=1, tag, and target.
  - In both cases `lru` of the set becomes the other way.
- Flush:
  - clears all valid bits and all `lru` bits at the next edge.
  - has priority over a load and over an LRU touch in the same cycle; the load is dropped.
- Simultaneous load and lookup LRU touch to the same set: the load's LRU update wins. Different sets update independently.
- Reset:
  - all valid=0, all `lru`=0.
  - tag and target arrays are not reset.
  - outputs during and after reset: `btb_hit`=0, `btb_target`=16'h0000.
  - Reset is asserted asynchronously and released synchronously to `clk` by the system.

## Timing
- Lookup latency is 0 cycles: outputs are purely combinational from `fetch_pc` and stored state.
- A write is visible to lookups from the cycle after the edge that captures it.
- There is no write-to-read bypass. A same-cycle lookup of `update_pc` returns the old contents.
- A flush takes effect the cycle after the capturing edge; `btb_hit`=0 for all PCs from then on.
- No handshake or stall: `load_btb` is a single-cycle pulse, and every asserted cycle is a separate write.
- Reset mid-operation clears state immediately, without waiting for `clk`. A load in flight at that moment is lost.

## Test plan
- Reset/empty:
  - Assert `rst_n`=0, release, drive `fetch_pc`=16'h3000.
  - Expect `btb_hit`=0, `btb_target`=0.
- Fill and hit:
  - Load 16'h3002 -> 16'h3040, then look up 16'h3002 next cycle.
  - Expect hit=1, target=16'h3040.
  - The same-cycle lookup of 16'h3002 during the load shows hit=0.
- Conflict and LRU:
  - At SETS=4, load 16'h3002, 16'h300A and 16'h3012 (all index 1).
  - Expect the third load to evict 16'h3002.
  - If a lookup hit on 16'h3002 (with `fetch_valid`=1) comes between the second and third loads, 16'h300A is evicted instead.
- Overwrite:
  - Reload 16'h3002 with target 16'h4000.
  - Expect hit returns 16'h4000 and the other way in set 1 is unchanged.
- Flush priority:
  - In one cycle, assert `flush`=1 and `load_btb`=1 for 16'h5004.
  - Next cycle, expect no hit for 16'h5004 or any previously loaded PC.
- Async reset mid-run:
  - Drop `rst_n` between clock edges after filling entries.
  - Expect `btb_hit` to go 0 immediately, not at the next edge.

Source files
------------

// File: rtl/lc3b_btb.sv
// lc3b_btb: two-way set-associative branch target buffer.
// Combinational fetch lookup, single-cycle update writes, one LRU bit per
// set, and a flush that invalidates every entry.
module lc3b_btb #(
  parameter int unsigned SETS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] fetch_pc,
  input  logic        fetch_valid,
  output logic        btb_hit,
  output logic [15:0] btb_target,
  input  logic        load_btb,
  input  logic [15:0] update_pc,
  input  logic [15:0] update_target,
  input  logic        flush
);

  localparam int unsigned IDX = $clog2(SETS);
  localparam int unsigned TW  = 15 - IDX;

  // Per-set state: valid bit per way, LRU bit names the way to evict next.
  logic [SETS-1:0][1:0] valid_q;
  logic [SETS-1:0]      lru_q;
  logic [TW-1:0]        tag_q    [SETS][2];
  logic [15:0]          target_q [SETS][2];

  logic [IDX-1:0] f_idx;
  logic [IDX-1:0] u_idx;
  logic [TW-1:0]  f_tag;
  logic [TW-1:0]  u_tag;
  logic [1:0]     f_match;
  logic [1:0]     u_match;
  logic           hit_way;
  logic           victim;

  // Word-aligned PCs: bit 0 carries no information.
  logic unused_lsbs;
  assign unused_lsbs = fetch_pc[0] ^ update_pc[0];

  assign f_idx = fetch_pc[IDX:1];
  assign f_tag = fetch_pc[15:IDX+1];
  assign u_idx = update_pc[IDX:1];
  assign u_tag = update_pc[15:IDX+1];

  // Fetch lookup: way 0 takes precedence should both ways ever match.
  always_comb begin
    f_match[0] = valid_q[f_idx][0] && (tag_q[f_idx][0] == f_tag);
    f_match[1] = valid_q[f_idx][1] && (tag_q[f_idx][1] == f_tag);
    btb_hit    = |f_match;
    hit_way    = !f_match[0];
    if (f_match[0])
      btb_target = target_q[f_idx][0];
    else if (f_match[1])
      btb_target = target_q[f_idx][1];
    else
      btb_target = '0;
  end

  // Write way selection: existing entry first, then free way, then LRU.
  always_comb begin
    u_match[0] = valid_q[u_idx][0] && (tag_q[u_idx][0] == u_tag);
    u_match[1] = valid_q[u_idx][1] && (tag_q[u_idx][1] == u_tag);
    if (u_match[0])
      victim = 1'b0;
    else if (u_match[1])
      victim = 1'b1;
    else if (!valid_q[u_idx][0])
      victim = 1'b0;
    else if (!valid_q[u_idx][1])
      victim = 1'b1;
    else
      victim = lru_q[u_idx];
  end

  // Valid and LRU state; flush beats load and touch, a load's LRU write
  // lands after the touch so it wins when both hit the same set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      lru_q   <= '0;
    end else if (flush) begin
      valid_q <= '0;
      lru_q   <= '0;
    end else begin
      if (fetch_valid && btb_hit)
        lru_q[f_idx] <= ~hit_way;
      if (load_btb) begin
        valid_q[u_idx][victim] <= 1'b1;
        lru_q[u_idx]           <= ~victim;
      end
    end
  end

  // Tag and target storage, not reset; qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (load_btb && !flush) begin
      tag_q[u_idx][victim]    <= u_tag;
      target_q[u_idx][victim] <= update_target;
    end
  end

endmodule

// File: tb/tb_lc3b_btb.sv
// Self-checking bench for lc3b_btb: expected lookup results are queued
// when a fetch PC is driven and popped when the outputs are sampled.
module tb_lc3b_btb;

  logic        clk;
  logic        rst_n;
  logic [15:0] fetch_pc;
  logic        fetch_valid;
  logic        btb_hit;
  logic [15:0] btb_target;
  logic        load_btb;
  logic [15:0] update_pc;
  logic [15:0] update_target;
  logic        flush;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [16:0] sb [$];

  lc3b_btb #(.SETS(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_pc      (fetch_pc),
    .fetch_valid   (fetch_valid),
    .btb_hit       (btb_hit),
    .btb_target    (btb_target),
    .load_btb      (load_btb),
    .update_pc     (update_pc),
    .update_target (update_target),
    .flush         (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and drop single-cycle controls.
  task automatic cycle();
    @(posedge clk);
    #1;
    load_btb    = 1'b0;
    flush       = 1'b0;
    fetch_valid = 1'b0;
  endtask

  task automatic drive_load(input logic [15:0] pc, input logic [15:0] tgt);
    load_btb      = 1'b1;
    update_pc     = pc;
    update_target = tgt;
  endtask

  task automatic look(input string tag, input logic [15:0] pc, input logic fv,
                      input logic eh, input logic [15:0] et);
    logic [16:0] exp;
    fetch_pc    = pc;
    fetch_valid = fv;
    sb.push_back({eh, et});
    #2;
    exp = sb.pop_front();
    check({tag, "_hit"}, {31'd0, btb_hit}, {31'd0, exp[16]});
    check({tag, "_tgt"}, {16'd0, btb_target}, {16'd0, exp[15:0]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    fetch_pc      = 16'h3000;
    fetch_valid   = 1'b0;
    load_btb      = 1'b0;
    update_pc     = '0;
    update_target = '0;
    flush         = 1'b0;

    // Reset and empty table
    #1;
    look("rst_hold", 16'h3000, 1'b0, 1'b0, 16'h0000);
    cycle();
    rst_n = 1'b1;
    look("rst_empty", 16'h3000, 1'b0, 1'b0, 16'h0000);

    // Fill and hit; no write-to-read bypass
    drive_load(16'h3002, 16'h3040);
    look("same_cycle", 16'h3002, 1'b0, 1'b0, 16'h0000);
    cycle();
    look("fill", 16'h3002, 1'b0, 1'b1, 16'h3040);

    // Second way, then conflict evicts the LRU way (3002)
    drive_load(16'h300A, 16'h30A0);
    cycle();
    look("way1_new", 16'h300A, 1'b0, 1'b1, 16'h30A0);
    look("way0_kept", 16'h3002, 1'b0, 1'b1, 16'h3040);
    drive_load(16'h3012, 16'h3120);
    cycle();
    look("evict_new", 16'h3012, 1'b0, 1'b1, 16'h3120);
    look("evict_old", 16'h3002, 1'b0, 1'b0, 16'h0000);
    look("evict_keep", 16'h300A, 1'b0, 1'b1, 16'h30A0);

    // Another set is independent
    drive_load(16'h3000, 16'h3333);
    cycle();
    look("set0", 16'h3000, 1'b0, 1'b1, 16'h3333);
    look("set1_intact", 16'h300A, 1'b0, 1'b1, 16'h30A0);

    // Flush wins over a same-cycle load
    flush = 1'b1;
    drive_load(16'h5004, 16'h5555);
    cycle();
    look("flush_load", 16'h5004, 1'b0, 1'b0, 16'h0000);
    look("flush_a", 16'h3012, 1'b0, 1'b0, 16'h0000);
    look("flush_b", 16'h3000, 1'b0, 1'b0, 16'h0000);

    // Lookup touch on 3002 redirects eviction to 300A
    drive_load(16'h3002, 16'h3040);
    cycle();
    drive_load(16'h300A, 16'h30A0);
    cycle();
    look("touch", 16'h3002, 1'b1, 1'b1, 16'h3040);
    cycle();
    drive_load(16'h3012, 16'h3120);
    cycle();
    look("touch_new", 16'h3012, 1'b0, 1'b1, 16'h3120);
    look("touch_kept", 16'h3002, 1'b0, 1'b1, 16'h3040);
    look("touch_evict", 16'h300A, 1'b0, 1'b0, 16'h0000);

    // Overwrite in place; LRU then points at the other way
    drive_load(16'h3002, 16'h4000);
    cycle();
    look("ovw_new", 16'h3002, 1'b0, 1'b1, 16'h4000);
    look("ovw_other", 16'h3012, 1'b0, 1'b1, 16'h3120);
    drive_load(16'h300A, 16'h30A0);
    cycle();
    look("ovw_lru_new", 16'h300A, 1'b0, 1'b1, 16'h30A0);
    look("ovw_lru_kept", 16'h3002, 1'b0, 1'b1, 16'h4000);
    look("ovw_lru_evict", 16'h3012, 1'b0, 1'b0, 16'h0000);

    // Asynchronous reset between edges
    look("pre_areset", 16'h3002, 1'b0, 1'b1, 16'h4000);
    #2;
    rst_n = 1'b0;
    look("areset_now", 16'h3002, 1'b0, 1'b0, 16'h0000);
    cycle();
    rst_n = 1'b1;
    look("post_areset_a", 16'h3002, 1'b0, 1'b0, 16'h0000);
    look("post_areset_b", 16'h3000, 1'b0, 1'b0, 16'h0000);
    cycle();

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
